// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: drives two WIDTH-bit operands LSB-first into an external
// bit-serial adder and closes its carry loop. The adder's sum bit is shifted
// back into a parallel word, and its carry flop output becomes the next carry.
//
// Handshake: a request is accepted on a posedge where start=1 and the block
// is IDLE. a, b and cin are captured on that edge. Nothing is queued.
// done pulses for one cycle when sum/cout are valid. sum/cout then hold until
// the next accepted start begins shifting new bits in.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             z,
  input  logic             ny,
  output logic             x1,
  output logic             x2,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic           last_bit;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic           carry;

  // State register; reset discards any operation in flight.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: IDLE waits for start, SHIFT runs WIDTH bits, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial outputs to the adder: live only while shifting, quiet otherwise.
  always_comb begin
    x1 = 1'b0;
    x2 = 1'b0;
    y  = 1'b0;
    if (state == SHIFT) begin
      x1 = a_sr[0];
      x2 = b_sr[0];
      y  = carry;
    end
  end

  // Operand capture, shifting, carry feedback and result collection.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
    end else if (state == SHIFT) begin
      cnt   <= cnt + 1'b1;
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      // ny was updated by the adder on the preceding negedge.
      carry <= ny;
      sum   <= {z, sum[WIDTH-1:1]};
      if (last_bit) cout <= ny;
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  assign dbg_state = state;

endmodule
